// File: rtl/mc_stage_seq_pkg.sv
// Shared definitions for the multi-cycle stage sequencer: state codes,
// the bundle of per-cycle control strobes, and small decode helpers.
package mc_stage_seq_pkg;

  // State encoding is fixed; the datapath and debug tooling decode these codes.
  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_IFW  = 3'd1,
    S_ID   = 3'd2,
    S_EXE  = 3'd3,
    S_MEM  = 3'd4,
    S_MEMW = 3'd5,
    S_WB   = 3'd6,
    S_ERR  = 3'd7
  } state_e;

  // Per-cycle control strobes driven toward the datapath and SRAM ports.
  typedef struct packed {
    logic inst_req;
    logic ir_we;
    logic ex_we;
    logic data_req;
    logic data_we;
    logic rf_we;
    logic pc_we;
    logic retire;
  } stage_ctl_t;

  localparam stage_ctl_t CTL_IDLE = '0;

  // States in which the sequencer waits on an SRAM ok handshake.
  function automatic logic is_wait_state(input state_e s);
    return (s == S_IFW) || (s == S_MEMW);
  endfunction

  // States whose cycle immediately precedes a wait state; the watchdog
  // timer is cleared there so it starts from zero on wait-state entry.
  function automatic logic is_pre_wait_state(input state_e s);
    return (s == S_IF) || (s == S_MEM);
  endfunction

endpackage

// File: rtl/mc_stage_seq_wait_timer.sv
// Wait-state watchdog counter. Cleared on entry to a wait state, counts
// wait cycles without a response, and flags expiry at the all-ones count.
// The count saturates so expiry stays asserted until the next clear.
module mc_wait_timer #(
  parameter int unsigned TMO_W = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  input  logic i_inc,
  output logic o_expired
);

  logic [TMO_W-1:0] r_cnt;
  logic             w_full;

  assign w_full    = (r_cnt == '1);
  assign o_expired = w_full;

  // Clear has priority over increment; hold at all-ones once reached.
  always_ff @(posedge clk) begin
    if (reset || i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && !w_full) begin
      r_cnt <= r_cnt + TMO_W'(1);
    end
  end

endmodule

// File: rtl/mc_stage_seq.sv
// Multi-cycle IF/ID/EXE/MEM/WB stage sequencer. Generates datapath enables
// and SRAM request strobes, waits on variable-latency ok handshakes under a
// watchdog, and maintains cycle / retired-instruction / stall counters.
module mc_stage_seq
  import mc_stage_seq_pkg::*;
#(
  parameter int unsigned TMO_W  = 8,
  parameter int unsigned CNT_W  = 32,
  parameter bit          TMO_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inst_ok,
  input  logic             data_ok,
  input  logic             dec_br_only,
  input  logic             dec_load,
  input  logic             dec_store,
  input  logic             dec_gr_we,
  input  logic             br_taken,
  output logic             inst_req,
  output logic             ir_we,
  output logic             ex_we,
  output logic             data_req,
  output logic             data_we,
  output logic             rf_we,
  output logic             pc_we,
  output logic             pc_sel_br,
  output logic             retire,
  output logic             err,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] cyc_cnt,
  output logic [CNT_W-1:0] instret_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  state_e           r_state;
  logic             r_pc_sel_br;
  logic             r_err;
  logic [CNT_W-1:0] r_cyc_cnt;
  logic [CNT_W-1:0] r_instret_cnt;
  logic [CNT_W-1:0] r_stall_cnt;

  logic             w_wait;
  logic             w_ok;
  logic             w_stall;
  logic             w_expired_raw;
  logic             w_expired;
  logic             w_tmo;
  logic             w_clr;
  logic             w_pc_sel_br;
  stage_ctl_t       w_ctl;

  // Handshake qualification: each ok is only meaningful in its own wait state.
  assign w_wait    = is_wait_state(r_state);
  assign w_ok      = ((r_state == S_IFW)  && inst_ok) ||
                     ((r_state == S_MEMW) && data_ok);
  assign w_stall   = w_wait && !w_ok;
  assign w_expired = TMO_EN ? w_expired_raw : 1'b0;
  // A response arriving in the expiry cycle is accepted rather than faulted.
  assign w_tmo     = w_stall && w_expired;
  assign w_clr     = is_pre_wait_state(r_state);

  mc_wait_timer #(
    .TMO_W (TMO_W)
  ) u_wait_timer (
    .clk       (clk),
    .reset     (reset),
    .i_clr     (w_clr),
    .i_inc     (w_stall),
    .o_expired (w_expired_raw)
  );

  // Decode control strobes from the current state and decode/handshake inputs.
  always_comb begin
    w_ctl = CTL_IDLE;
    if (!reset) begin
      case (r_state)
        S_IF: begin
          w_ctl.inst_req = 1'b1;
        end
        S_IFW: begin
          w_ctl.ir_we = inst_ok;
        end
        S_ID: begin
          if (dec_br_only) begin
            w_ctl.pc_we  = 1'b1;
            w_ctl.retire = 1'b1;
          end
        end
        S_EXE: begin
          w_ctl.ex_we = 1'b1;
        end
        S_MEM: begin
          w_ctl.data_req = 1'b1;
          w_ctl.data_we  = dec_store;
        end
        S_MEMW: begin
          if (data_ok && dec_store) begin
            w_ctl.pc_we  = 1'b1;
            w_ctl.retire = 1'b1;
          end
        end
        S_WB: begin
          w_ctl.rf_we  = dec_gr_we;
          w_ctl.pc_we  = 1'b1;
          w_ctl.retire = 1'b1;
        end
        default: begin
          w_ctl = CTL_IDLE;
        end
      endcase
    end
  end

  // Branch select follows br_taken live in S_ID so a branch-only PC update
  // in that same cycle sees it; elsewhere the value captured in S_ID is held.
  always_comb begin
    w_pc_sel_br = r_pc_sel_br;
    if (!reset && (r_state == S_ID)) begin
      w_pc_sel_br = br_taken;
    end
  end

  // Stage FSM, sticky error flag, branch-select capture and counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= S_IF;
      r_pc_sel_br   <= 1'b0;
      r_err         <= 1'b0;
      r_cyc_cnt     <= '0;
      r_instret_cnt <= '0;
      r_stall_cnt   <= '0;
    end else begin
      if (r_state != S_ERR) begin
        r_cyc_cnt <= r_cyc_cnt + CNT_W'(1);
      end
      if (w_ctl.retire) begin
        r_instret_cnt <= r_instret_cnt + CNT_W'(1);
      end
      if (w_stall) begin
        r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      end

      case (r_state)
        S_IF: begin
          r_state <= S_IFW;
        end
        S_IFW: begin
          if (inst_ok) begin
            r_state <= S_ID;
          end else if (w_tmo) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end
        end
        S_ID: begin
          r_pc_sel_br <= br_taken;
          r_state     <= dec_br_only ? S_IF : S_EXE;
        end
        S_EXE: begin
          r_state <= (dec_load || dec_store) ? S_MEM : S_WB;
        end
        S_MEM: begin
          r_state <= S_MEMW;
        end
        S_MEMW: begin
          if (data_ok) begin
            r_state <= dec_store ? S_IF : S_WB;
          end else if (w_tmo) begin
            r_state <= S_ERR;
            r_err   <= 1'b1;
          end
        end
        S_WB: begin
          r_state <= S_IF;
        end
        S_ERR: begin
          r_state <= S_ERR;
        end
        default: begin
          r_state <= S_ERR;
          r_err   <= 1'b1;
        end
      endcase
    end
  end

  assign inst_req    = w_ctl.inst_req;
  assign ir_we       = w_ctl.ir_we;
  assign ex_we       = w_ctl.ex_we;
  assign data_req    = w_ctl.data_req;
  assign data_we     = w_ctl.data_we;
  assign rf_we       = w_ctl.rf_we;
  assign pc_we       = w_ctl.pc_we;
  assign retire      = w_ctl.retire;
  assign pc_sel_br   = w_pc_sel_br;
  assign err         = r_err;
  assign state       = r_state;
  assign cyc_cnt     = r_cyc_cnt;
  assign instret_cnt = r_instret_cnt;
  assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_mc_stage_seq.sv
// Directed bench for mc_stage_seq: ALU op, load, taken branch, store,
// reset mid-access, watchdog boundary (ok on the expiry cycle) and timeout.
module tb_mc_stage_seq;
  import mc_stage_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inst_ok = 1'b0;
  logic        data_ok = 1'b0;
  logic        dec_br_only = 1'b0;
  logic        dec_load = 1'b0;
  logic        dec_store = 1'b0;
  logic        dec_gr_we = 1'b0;
  logic        br_taken = 1'b0;
  logic        inst_req, ir_we, ex_we, data_req, data_we;
  logic        rf_we, pc_we, pc_sel_br, retire, err;
  logic [2:0]  state;
  logic [31:0] cyc_cnt, instret_cnt, stall_cnt;

  int n_vec = 0;
  int n_err = 0;
  int k = 0;

  mc_stage_seq #(
    .TMO_W  (4),
    .CNT_W  (32),
    .TMO_EN (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .inst_ok     (inst_ok),
    .data_ok     (data_ok),
    .dec_br_only (dec_br_only),
    .dec_load    (dec_load),
    .dec_store   (dec_store),
    .dec_gr_we   (dec_gr_we),
    .br_taken    (br_taken),
    .inst_req    (inst_req),
    .ir_we       (ir_we),
    .ex_we       (ex_we),
    .data_req    (data_req),
    .data_we     (data_we),
    .rf_we       (rf_we),
    .pc_we       (pc_we),
    .pc_sel_br   (pc_sel_br),
    .retire      (retire),
    .err         (err),
    .state       (state),
    .cyc_cnt     (cyc_cnt),
    .instret_cnt (instret_cnt),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Advance to the next cycle's negedge; k numbers cycles within an instruction.
  task automatic adv();
    @(negedge clk);
    k++;
  endtask

  // Called at the negedge of an S_IF cycle; leaves the bench at the S_ID negedge.
  task automatic fetch(input int li);
    inst_ok = 1'b0;
    #1;
    chk("if_state", 32'(state), 32'(S_IF));
    chk("if_inst_req", 32'(inst_req), 1);
    for (int i = 0; i < li; i++) begin
      adv();
      #1;
      chk("ifw_state", 32'(state), 32'(S_IFW));
      chk("ifw_ir_we_idle", 32'(ir_we), 0);
    end
    adv();
    inst_ok = 1'b1;
    #1;
    chk("ifw_ok_state", 32'(state), 32'(S_IFW));
    chk("ifw_ir_we", 32'(ir_we), 1);
    adv();
    inst_ok = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL tb_timeout: got no finish, want finish");
    $fatal(1);
  end

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(S_IF));
    chk("rst_err", 32'(err), 0);
    chk("rst_inst_req", 32'(inst_req), 0);
    chk("rst_pc_sel_br", 32'(pc_sel_br), 0);
    chk("rst_cyc", cyc_cnt, 0);
    chk("rst_instret", instret_cnt, 0);
    chk("rst_stall", stall_cnt, 0);
    reset = 1'b0;

    // add.w, ok one cycle after req: states 0,1,2,3,6,0
    k = 1;
    dec_gr_we = 1'b1;
    fetch(0);
    #1;
    chk("add_id_state", 32'(state), 32'(S_ID));
    chk("add_id_pc_we", 32'(pc_we), 0);
    adv(); #1;
    chk("add_exe_state", 32'(state), 32'(S_EXE));
    chk("add_ex_we", 32'(ex_we), 1);
    adv(); #1;
    chk("add_wb_state", 32'(state), 32'(S_WB));
    chk("add_rf_we", 32'(rf_we), 1);
    chk("add_retire", 32'(retire), 1);
    chk("add_pc_we", 32'(pc_we), 1);
    chk("add_pc_sel_br", 32'(pc_sel_br), 0);
    chk("add_ret_cycle", 32'(k), 5);
    adv(); #1;
    chk("add_next_state", 32'(state), 32'(S_IF));
    chk("add_instret", instret_cnt, 1);
    chk("add_cyc", cyc_cnt, 5);
    chk("add_stall", stall_cnt, 0);

    // ld.w, Li=3, Ld=2: retire in cycle 12
    k = 1;
    dec_load = 1'b1;
    fetch(3);
    #1;
    chk("ld_id_state", 32'(state), 32'(S_ID));
    adv(); #1;
    chk("ld_exe_state", 32'(state), 32'(S_EXE));
    adv(); #1;
    chk("ld_mem_state", 32'(state), 32'(S_MEM));
    chk("ld_data_req", 32'(data_req), 1);
    chk("ld_data_we", 32'(data_we), 0);
    for (int i = 0; i < 2; i++) begin
      adv(); #1;
      chk("ld_memw_state", 32'(state), 32'(S_MEMW));
      chk("ld_memw_retire", 32'(retire), 0);
      chk("ld_memw_data_req", 32'(data_req), 0);
    end
    adv();
    data_ok = 1'b1;
    #1;
    chk("ld_memw_ok_retire", 32'(retire), 0);
    adv();
    data_ok = 1'b0;
    #1;
    chk("ld_wb_state", 32'(state), 32'(S_WB));
    chk("ld_rf_we", 32'(rf_we), 1);
    chk("ld_retire", 32'(retire), 1);
    chk("ld_ret_cycle", 32'(k), 12);
    adv(); #1;
    chk("ld_next_state", 32'(state), 32'(S_IF));
    chk("ld_stall", stall_cnt, 5);
    chk("ld_instret", instret_cnt, 2);
    chk("ld_cyc", cyc_cnt, 17);
    dec_load = 1'b0;

    // beq taken, Li=2: retires in S_ID at cycle 5
    k = 1;
    dec_gr_we = 1'b0;
    fetch(2);
    dec_br_only = 1'b1;
    br_taken = 1'b1;
    #1;
    chk("br_id_state", 32'(state), 32'(S_ID));
    chk("br_pc_we", 32'(pc_we), 1);
    chk("br_pc_sel_br", 32'(pc_sel_br), 1);
    chk("br_retire", 32'(retire), 1);
    chk("br_ex_we", 32'(ex_we), 0);
    chk("br_rf_we", 32'(rf_we), 0);
    chk("br_ret_cycle", 32'(k), 5);
    adv();
    br_taken = 1'b0;
    #1;
    chk("br_next_state", 32'(state), 32'(S_IF));
    chk("br_sel_held", 32'(pc_sel_br), 1);
    chk("br_instret", instret_cnt, 3);
    chk("br_cyc", cyc_cnt, 22);
    dec_br_only = 1'b0;

    // st.w, Li=0, data_ok after 4 wait cycles: retire in S_MEMW at cycle 10
    k = 1;
    dec_store = 1'b1;
    dec_gr_we = 1'b1;
    fetch(0);
    #1;
    chk("st_id_sel_br", 32'(pc_sel_br), 0);
    adv(); #1;
    chk("st_exe_state", 32'(state), 32'(S_EXE));
    adv(); #1;
    chk("st_data_req", 32'(data_req), 1);
    chk("st_data_we", 32'(data_we), 1);
    for (int i = 0; i < 4; i++) begin
      adv(); #1;
      chk("st_memw_state", 32'(state), 32'(S_MEMW));
      chk("st_memw_pc_we", 32'(pc_we), 0);
      chk("st_memw_rf_we", 32'(rf_we), 0);
    end
    adv();
    data_ok = 1'b1;
    #1;
    chk("st_pc_we", 32'(pc_we), 1);
    chk("st_retire", 32'(retire), 1);
    chk("st_rf_we", 32'(rf_we), 0);
    chk("st_ret_cycle", 32'(k), 10);
    adv();
    data_ok = 1'b0;
    #1;
    chk("st_next_state", 32'(state), 32'(S_IF));
    chk("st_rf_we_after", 32'(rf_we), 0);
    chk("st_sel_br", 32'(pc_sel_br), 0);
    chk("st_cyc", cyc_cnt, 32);
    chk("st_instret", instret_cnt, 4);
    chk("st_stall", stall_cnt, 11);
    dec_store = 1'b0;
    dec_gr_we = 1'b0;

    // Reset during S_MEMW of a load, then a stray data_ok in S_IF
    k = 1;
    dec_load = 1'b1;
    fetch(0);
    adv(); adv(); adv();
    #1;
    chk("rmw_state", 32'(state), 32'(S_MEMW));
    reset = 1'b1;
    adv();
    reset = 1'b0;
    dec_load = 1'b0;
    data_ok = 1'b1;
    k = 1;
    #1;
    chk("rmw_state_if", 32'(state), 32'(S_IF));
    chk("rmw_data_req", 32'(data_req), 0);
    chk("rmw_cyc", cyc_cnt, 0);
    chk("rmw_instret", instret_cnt, 0);
    adv();
    data_ok = 1'b0;
    #1;
    chk("rmw_stray_ignored", 32'(state), 32'(S_IFW));

    // Watchdog boundary: inst_ok on the all-ones cycle is accepted
    repeat (14) adv();
    #1;
    chk("wd_edge_state", 32'(state), 32'(S_IFW));
    adv();
    inst_ok = 1'b1;
    #1;
    chk("wd_edge_cycle", 32'(k), 17);
    chk("wd_edge_ir_we", 32'(ir_we), 1);
    adv();
    inst_ok = 1'b0;
    dec_br_only = 1'b1;
    #1;
    chk("wd_edge_id", 32'(state), 32'(S_ID));
    chk("wd_edge_err", 32'(err), 0);
    adv();
    dec_br_only = 1'b0;
    #1;
    chk("wd_edge_cyc", cyc_cnt, 18);
    chk("wd_edge_stall", stall_cnt, 15);

    // Watchdog timeout: inst_ok never arrives
    k = 1;
    repeat (16) adv();
    #1;
    chk("tmo_last_wait", 32'(state), 32'(S_IFW));
    adv();
    #1;
    chk("tmo_state", 32'(state), 32'(S_ERR));
    chk("tmo_err", 32'(err), 1);
    chk("tmo_cyc", cyc_cnt, 35);
    chk("tmo_stall", stall_cnt, 31);
    chk("tmo_inst_req", 32'(inst_req), 0);
    inst_ok = 1'b1;
    repeat (3) adv();
    #1;
    chk("err_frozen_cyc", cyc_cnt, 35);
    chk("err_frozen_stall", stall_cnt, 31);
    chk("err_state_held", 32'(state), 32'(S_ERR));
    chk("err_sticky", 32'(err), 1);
    chk("err_ir_we", 32'(ir_we), 0);
    chk("err_pc_we", 32'(pc_we), 0);
    inst_ok = 1'b0;
    reset = 1'b1;
    adv();
    reset = 1'b0;
    #1;
    chk("post_rst_state", 32'(state), 32'(S_IF));
    chk("post_rst_err", 32'(err), 0);
    chk("post_rst_cyc", cyc_cnt, 0);
    chk("post_rst_instret", instret_cnt, 0);
    chk("post_rst_stall", stall_cnt, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
